mem_bus_arbiter: RTL and testbench

Two-master arbiter and sequencer for the system memory bus in front of the internal memory / external memory decode. Master 0 is the CPU core's load/store/fetch port and master 1 is a DMA/debug requester. The block runs round-robin arbitration, registers the winning request onto a single memory port, and waits for `mem_ready`. It then returns read data and a completion pulse to the granted master, with an optional bus-timeout abort.

---
 rtl/mem_bus_arbiter_if.sv | 42 ++++
 rtl/mem_bus_arbiter.sv | 158 +++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_if.sv
// Memory bus bundle between the two requesters, the arbiter and the memory port.
// The arbiter takes the master modport (it masters the memory port); the bench/environment uses slave.
interface mem_bus_arbiter_if;
    logic        m0_req;
    logic        m1_req;
    logic        m0_we;
    logic        m1_we;
    logic [31:0] m0_addr;
    logic [31:0] m1_addr;
    logic [31:0] m0_wdata;
    logic [31:0] m1_wdata;
    logic [2:0]  m0_width;
    logic [2:0]  m1_width;
    logic        m0_gnt;
    logic        m1_gnt;
    logic        m0_done;
    logic        m1_done;
    logic        m0_err;
    logic        m1_err;
    logic [31:0] m_rdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  mem_op_width;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport master (
        input  m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr,
               m0_wdata, m1_wdata, m0_width, m1_width, mem_rdata, mem_ready,
        output m0_gnt, m1_gnt, m0_done, m1_done, m0_err, m1_err, m_rdata,
               mem_addr, mem_wdata, mem_read, mem_write, mem_op_width
    );

    modport slave (
        output m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr,
               m0_wdata, m1_wdata, m0_width, m1_width, mem_rdata, mem_ready,
        input  m0_gnt, m1_gnt, m0_done, m1_done, m0_err, m1_err, m_rdata,
               mem_addr, mem_wdata, mem_read, mem_write, mem_op_width
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter/sequencer onto a single registered memory port.
// Optional bus-timeout abort is built only when ARB_TIMEOUT_EN is defined.
module mem_bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
    input logic               clk,
    input logic               rst_n,
    mem_bus_arbiter_if.master bus
);
    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state;
    state_t      state_nxt;
    logic        start;
    logic        finish;
    logic        abort;
    logic        timeout_hit;
    logic        pick_m1;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [2:0]  sel_width;

    logic        last_gnt;
    logic        gnt0_r;
    logic        gnt1_r;
    logic        done0_r;
    logic        done1_r;
    logic        rd_r;
    logic        wr_r;
    logic [31:0] addr_r;
    logic [31:0] wdata_r;
    logic [2:0]  width_r;
    logic [31:0] rdata_r;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be within 1..65535");
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        finish    = 1'b0;
        abort     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.m0_req || bus.m1_req) begin
                    start     = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                // mem_ready beats a timeout landing in the same cycle
                if (bus.mem_ready) begin
                    finish    = 1'b1;
                    state_nxt = IDLE;
                end else if (timeout_hit) begin
                    finish    = 1'b1;
                    abort     = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        pick_m1   = bus.m1_req && (!bus.m0_req || !last_gnt);
        sel_we    = pick_m1 ? bus.m1_we    : bus.m0_we;
        sel_addr  = pick_m1 ? bus.m1_addr  : bus.m0_addr;
        sel_wdata = pick_m1 ? bus.m1_wdata : bus.m0_wdata;
        sel_width = pick_m1 ? bus.m1_width : bus.m0_width;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt <= 1'b1;
            gnt0_r   <= 1'b0;
            gnt1_r   <= 1'b0;
            done0_r  <= 1'b0;
            done1_r  <= 1'b0;
            rd_r     <= 1'b0;
            wr_r     <= 1'b0;
            addr_r   <= '0;
            wdata_r  <= '0;
            width_r  <= 3'b010;
            rdata_r  <= '0;
        end else begin
            done0_r <= 1'b0;
            done1_r <= 1'b0;
            if (start) begin
                gnt0_r   <= !pick_m1;
                gnt1_r   <= pick_m1;
                last_gnt <= pick_m1;
                rd_r     <= !sel_we;
                wr_r     <= sel_we;
                addr_r   <= sel_addr;
                wdata_r  <= sel_wdata;
                width_r  <= sel_width;
            end else if (finish) begin
                gnt0_r  <= 1'b0;
                gnt1_r  <= 1'b0;
                rd_r    <= 1'b0;
                wr_r    <= 1'b0;
                done0_r <= gnt0_r;
                done1_r <= gnt1_r;
                if (rd_r) rdata_r <= abort ? ERR_DATA : bus.mem_rdata;
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] to_cnt;
    logic        err0_r;
    logic        err1_r;

    assign timeout_hit = (to_cnt == TO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
            err0_r <= 1'b0;
            err1_r <= 1'b0;
        end else begin
            err0_r <= finish && abort && gnt0_r;
            err1_r <= finish && abort && gnt1_r;
            if (start)                              to_cnt <= '0;
            else if (state == BUSY && !bus.mem_ready) to_cnt <= to_cnt + 16'd1;
        end
    end

    assign bus.m0_err = err0_r;
    assign bus.m1_err = err1_r;
`else
    assign timeout_hit = 1'b0;
    assign bus.m0_err  = 1'b0;
    assign bus.m1_err  = 1'b0;
`endif

    assign bus.m0_gnt       = gnt0_r;
    assign bus.m1_gnt       = gnt1_r;
    assign bus.m0_done      = done0_r;
    assign bus.m1_done      = done1_r;
    assign bus.m_rdata      = rdata_r;
    assign bus.mem_addr     = addr_r;
    assign bus.mem_wdata    = wdata_r;
    assign bus.mem_read     = rd_r;
    assign bus.mem_write    = wr_r;
    assign bus.mem_op_width = width_r;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: reset, single read, contention, waited write,
// mid-transaction reset, and either timeout abort or indefinite wait depending on ARB_TIMEOUT_EN.
module tb_mem_bus_arbiter;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    mem_bus_arbiter_if bus ();

    mem_bus_arbiter #(.TIMEOUT_CYCLES(4), .ERR_DATA(32'hDEADBEEF)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {m0_gnt, m1_gnt, m0_done, m1_done, m0_err, m1_err, mem_read, mem_write}
    function automatic logic [7:0] ctl();
        return {bus.m0_gnt, bus.m1_gnt, bus.m0_done, bus.m1_done,
                bus.m0_err, bus.m1_err, bus.mem_read, bus.mem_write};
    endfunction

    task automatic clear_inputs();
        bus.m0_req = 0; bus.m1_req = 0; bus.m0_we = 0; bus.m1_we = 0;
        bus.m0_addr = 0; bus.m1_addr = 0; bus.m0_wdata = 0; bus.m1_wdata = 0;
        bus.m0_width = 3'b010; bus.m1_width = 3'b010;
        bus.mem_rdata = 0; bus.mem_ready = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        do_reset();
        checks++;
        if (ctl() !== 8'b0) begin
            $display("FAIL reset_ctl got=%b want=%b", ctl(), 8'b0); failures++;
        end
        checks++;
        if ({bus.mem_addr, bus.mem_wdata, bus.m_rdata} !== 96'h0) begin
            $display("FAIL reset_data got=%h %h %h want=0", bus.mem_addr, bus.mem_wdata, bus.m_rdata); failures++;
        end
        checks++;
        if (bus.mem_op_width !== 3'b010) begin
            $display("FAIL reset_width got=%b want=010", bus.mem_op_width); failures++;
        end
    endtask

    task automatic test_single_read();
        bus.mem_ready = 1; bus.mem_rdata = 32'h2001002A;
        bus.m0_req = 1; bus.m0_we = 0; bus.m0_addr = 32'h00008000; bus.m0_width = 3'b010;
        tick();
        checks++;
        if (ctl() !== 8'b1000_0010) begin
            $display("FAIL rd_grant got=%b want=%b", ctl(), 8'b1000_0010); failures++;
        end
        checks++;
        if (bus.mem_addr !== 32'h00008000 || bus.mem_op_width !== 3'b010) begin
            $display("FAIL rd_addr got=%h/%b want=00008000/010", bus.mem_addr, bus.mem_op_width); failures++;
        end
        tick();
        checks++;
        if (ctl() !== 8'b0010_0000) begin
            $display("FAIL rd_done got=%b want=%b", ctl(), 8'b0010_0000); failures++;
        end
        checks++;
        if (bus.m_rdata !== 32'h2001002A) begin
            $display("FAIL rd_data got=%h want=2001002A", bus.m_rdata); failures++;
        end
        bus.m0_req = 0;
        tick();
        checks++;
        if (ctl() !== 8'b0) begin
            $display("FAIL rd_after got=%b want=%b", ctl(), 8'b0); failures++;
        end
    endtask

    task automatic test_round_robin();
        logic [7:0]  exp_g;
        logic [7:0]  exp_d;
        logic [31:0] exp_a;
        clear_inputs();
        do_reset();
        bus.mem_ready = 1; bus.mem_rdata = 32'h2001002A;
        bus.m0_addr = 32'h00001000; bus.m1_addr = 32'h00003000;
        bus.m0_req = 1; bus.m1_req = 1;
        for (int i = 0; i < 4; i++) begin
            exp_g = (i % 2 == 0) ? 8'b1000_0010 : 8'b0100_0010;
            exp_d = (i % 2 == 0) ? 8'b0010_0000 : 8'b0001_0000;
            exp_a = (i % 2 == 0) ? 32'h00001000 : 32'h00003000;
            tick();
            checks++;
            if (ctl() !== exp_g || bus.mem_addr !== exp_a) begin
                $display("FAIL rr_grant%0d got=%b/%h want=%b/%h", i, ctl(), bus.mem_addr, exp_g, exp_a); failures++;
            end
            if (i == 3) begin
                bus.m0_req = 0; bus.m1_req = 0;
            end
            tick();
            checks++;
            if (ctl() !== exp_d) begin
                $display("FAIL rr_done%0d got=%b want=%b", i, ctl(), exp_d); failures++;
            end
        end
        tick();
        checks++;
        if (ctl() !== 8'b0) begin
            $display("FAIL rr_idle got=%b want=%b", ctl(), 8'b0); failures++;
        end
    endtask

    task automatic test_write_wait();
        int dones;
        bus.mem_ready = 0; bus.mem_rdata = 32'hA5A5A5A5;
        bus.m1_req = 1; bus.m1_we = 1; bus.m1_addr = 32'h00002000;
        bus.m1_wdata = 32'h12345678; bus.m1_width = 3'b000;
        dones = 0;
        tick();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (ctl() !== 8'b0100_0001 || bus.mem_op_width !== 3'b000 ||
                bus.mem_addr !== 32'h00002000 || bus.mem_wdata !== 32'h12345678) begin
                $display("FAIL wr_busy%0d got=%b/%b/%h/%h want=01000001/000/00002000/12345678",
                         k, ctl(), bus.mem_op_width, bus.mem_addr, bus.mem_wdata); failures++;
            end
            if (k == 3) bus.mem_ready = 1;
            tick();
        end
        checks++;
        if (ctl() !== 8'b0001_0000) begin
            $display("FAIL wr_done got=%b want=%b", ctl(), 8'b0001_0000); failures++;
        end
        checks++;
        if (bus.m_rdata !== 32'h2001002A) begin
            $display("FAIL wr_rdata got=%h want=2001002A", bus.m_rdata); failures++;
        end
        bus.m1_req = 0; bus.mem_ready = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (bus.m1_done) dones++;
        end
        checks++;
        if (dones !== 0) begin
            $display("FAIL wr_extra_done got=%0d want=0", dones); failures++;
        end
    endtask

    task automatic test_reset_mid();
        bus.mem_ready = 0; bus.m0_req = 1; bus.m0_we = 0;
        bus.m0_addr = 32'h00004444; bus.m0_width = 3'b001;
        tick();
        tick();
        checks++;
        if (ctl() !== 8'b1000_0010) begin
            $display("FAIL mid_busy got=%b want=%b", ctl(), 8'b1000_0010); failures++;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (ctl() !== 8'b0 || bus.mem_addr !== 32'h0 || bus.m_rdata !== 32'h0 || bus.mem_op_width !== 3'b010) begin
            $display("FAIL mid_async got=%b/%h/%h/%b want=0/0/0/010",
                     ctl(), bus.mem_addr, bus.m_rdata, bus.mem_op_width); failures++;
        end
        bus.m0_req = 0;
        tick();
        checks++;
        if (ctl() !== 8'b0) begin
            $display("FAIL mid_nodone got=%b want=%b", ctl(), 8'b0); failures++;
        end
        rst_n = 1'b1;
        bus.m0_req = 1; bus.m1_req = 1; bus.mem_ready = 1;
        bus.m0_addr = 32'h00000010; bus.m1_addr = 32'h00000020;
        tick();
        checks++;
        if (ctl() !== 8'b1000_0010 || bus.mem_addr !== 32'h00000010) begin
            $display("FAIL mid_tie got=%b/%h want=10000010/00000010", ctl(), bus.mem_addr); failures++;
        end
        bus.m0_req = 0; bus.m1_req = 0;
        tick();
        tick();
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        clear_inputs();
        do_reset();
        bus.mem_rdata = 32'h0BADF00D;
        bus.m0_req = 1; bus.m0_we = 0; bus.m0_addr = 32'h00009000;
        tick();
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (ctl() !== 8'b1000_0010) begin
                $display("FAIL to_wait%0d got=%b want=%b", k, ctl(), 8'b1000_0010); failures++;
            end
        end
        tick();
        checks++;
        if (ctl() !== 8'b0010_1000 || bus.m_rdata !== 32'hDEADBEEF) begin
            $display("FAIL to_abort got=%b/%h want=00101000/DEADBEEF", ctl(), bus.m_rdata); failures++;
        end
        tick();
        for (int k = 0; k < 3; k++) tick();
        bus.mem_ready = 1;
        tick();
        checks++;
        if (ctl() !== 8'b0010_0000 || bus.m_rdata !== 32'h0BADF00D) begin
            $display("FAIL to_race got=%b/%h want=00100000/0BADF00D", ctl(), bus.m_rdata); failures++;
        end
        bus.m0_req = 0; bus.mem_ready = 0;
        tick();
    endtask
`else
    task automatic test_no_timeout();
        int bad;
        clear_inputs();
        do_reset();
        bus.mem_rdata = 32'h0BADF00D;
        bus.m0_req = 1; bus.m0_we = 0; bus.m0_addr = 32'h00009000;
        tick();
        bad = 0;
        for (int k = 0; k < 1000; k++) begin
            if (ctl() !== 8'b1000_0010) bad++;
            tick();
        end
        checks++;
        if (bad !== 0) begin
            $display("FAIL hang_busy got=%0d bad cycles want=0", bad); failures++;
        end
        bus.mem_ready = 1;
        tick();
        checks++;
        if (ctl() !== 8'b0010_0000 || bus.m_rdata !== 32'h0BADF00D) begin
            $display("FAIL hang_done got=%b/%h want=00100000/0BADF00D", ctl(), bus.m_rdata); failures++;
        end
        bus.m0_req = 0; bus.mem_ready = 0;
        tick();
    endtask
`endif

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        test_reset();
        test_single_read();
        test_round_robin();
        test_write_wait();
        test_reset_mid();
`ifdef ARB_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
